// File: rtl/pbkdf2_block_ctrl.sv
// PBKDF2 front-end controller: loads an 80-byte header, issues one HMAC-SHA256 request per block index, and collects the B vector.
// Optional build macro PBKDF2_NONCE_INSERT_EN substitutes a host-latched nonce for header word 19.
module pbkdf2_block_ctrl #(
    parameter int NUM_BLOCKS = 4,
    parameter int HDR_WORDS  = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 word_in,
    input  logic                        word_valid,
    output logic                        word_ready,
    output logic [2*HDR_WORDS*32+31:0]  hmac_data,
    output logic                        hmac_enable,
    input  logic [255:0]                hmac_hash,
    input  logic                        hmac_hash_done,
    output logic [NUM_BLOCKS*256-1:0]   b_out,
    output logic                        b_valid,
    input  logic                        b_ready,
    output logic                        busy,
`ifdef PBKDF2_NONCE_INSERT_EN
    input  logic [31:0]                 nonce_in,
    input  logic                        nonce_load,
`endif
    output logic [2:0]                  state_dbg
);

    // Handshakes: a word moves when word_valid & word_ready at a rising edge;
    // B is consumed when b_valid & b_ready at a rising edge. hmac_enable is a
    // single-cycle request; hmac_data stays stable until its hmac_hash_done.

    localparam int HDR_W = HDR_WORDS * 32;
    localparam int CNT_W = $clog2(HDR_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(HDR_WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, OUT} state_t;

    state_t           state;
    state_t           state_next;
    logic [HDR_W-1:0] header;
    logic [CNT_W-1:0] word_cnt;
    logic [31:0]      index;
    logic             word_hs;
    logic             last_block;
`ifdef PBKDF2_NONCE_INSERT_EN
    logic [31:0]      nonce_q;
`endif

    assign hmac_data  = {header, header, index};
    assign state_dbg  = state;
    assign word_hs    = word_ready & word_valid;
    assign last_block = (index == 32'(NUM_BLOCKS));

    always_comb begin
        state_next  = state;
        word_ready  = 1'b0;
        hmac_enable = 1'b0;
        b_valid     = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                word_ready = ~rst;
                if (word_valid) state_next = LOAD;
            end
            LOAD: begin
                word_ready = ~rst;
                if (word_valid && word_cnt == LAST_WORD) state_next = ISSUE;
            end
            ISSUE: begin
                hmac_enable = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                if (hmac_hash_done) state_next = last_block ? OUT : ISSUE;
            end
            OUT: begin
                b_valid = 1'b1;
                if (b_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            header   <= '0;
            word_cnt <= '0;
            index    <= '0;
            b_out    <= '0;
`ifdef PBKDF2_NONCE_INSERT_EN
            nonce_q  <= '0;
`endif
        end else begin
            state <= state_next;
            if (word_hs) begin
                for (int k = 0; k < HDR_WORDS; k++) begin
                    if (word_cnt == CNT_W'(k)) header[HDR_W-1-32*k -: 32] <= word_in;
                end
                if (word_cnt == LAST_WORD) begin
                    word_cnt <= '0;
                    index    <= 32'd1;
`ifdef PBKDF2_NONCE_INSERT_EN
                    // Later assignment wins over the streamed word 19 above.
                    header[31:0] <= nonce_q;
`endif
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
            if (state == WAIT && hmac_hash_done) begin
                for (int i = 0; i < NUM_BLOCKS; i++) begin
                    if (index == 32'(i + 1)) b_out[(NUM_BLOCKS-1-i)*256 +: 256] <= hmac_hash;
                end
                if (!last_block) index <= index + 32'd1;
            end
`ifdef PBKDF2_NONCE_INSERT_EN
            if (nonce_load && (state == IDLE || state == OUT)) nonce_q <= nonce_in;
`endif
        end
    end

endmodule

// File: tb/tb_pbkdf2_block_ctrl.sv
// Self-checking bench for pbkdf2_block_ctrl with a latency-randomized HMAC responder and a header/B reference model.
// Build with PBKDF2_NONCE_INSERT_EN defined to also exercise nonce insertion.
module tb_pbkdf2_block_ctrl;
    localparam int NB = 4;
    localparam int HW = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     word_in = '0;
    logic            word_valid = 1'b0;
    logic            word_ready;
    logic [1311:0]   hmac_data;
    logic            hmac_enable;
    logic [255:0]    hmac_hash;
    logic            hmac_hash_done;
    logic [NB*256-1:0] b_out;
    logic            b_valid;
    logic            b_ready = 1'b0;
    logic            busy;
    logic [2:0]      state_dbg;
`ifdef PBKDF2_NONCE_INSERT_EN
    logic [31:0]     nonce_in = '0;
    logic            nonce_load = 1'b0;
`endif

    always #5 clk = ~clk;

    pbkdf2_block_ctrl #(.NUM_BLOCKS(NB), .HDR_WORDS(HW)) dut (
        .clk(clk), .rst(rst),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .hmac_data(hmac_data), .hmac_enable(hmac_enable),
        .hmac_hash(hmac_hash), .hmac_hash_done(hmac_hash_done),
        .b_out(b_out), .b_valid(b_valid), .b_ready(b_ready), .busy(busy),
`ifdef PBKDF2_NONCE_INSERT_EN
        .nonce_in(nonce_in), .nonce_load(nonce_load),
`endif
        .state_dbg(state_dbg)
    );

    // HMAC responder and spurious-done sources are kept separate and ORed.
    logic         resp_done = 1'b0;
    logic         spur_issue_done = 1'b0;
    logic         spur_load_done = 1'b0;
    logic [255:0] resp_hash = '0;
    logic [255:0] spur_hash = '0;
    assign hmac_hash_done = resp_done | spur_issue_done | spur_load_done;
    assign hmac_hash      = resp_done ? resp_hash : spur_hash;

    int            n_checks = 0;
    int            n_fail = 0;
    int            lat_min = 10;
    int            lat_max = 10;
    logic          spur_in_issue = 1'b0;
    logic [31:0]   tag = '0;
    int            enable_count = 0;
    int            stable_err = 0;
    logic [1311:0] obs_q[$];
    logic [1311:0] exp_q[$];
    logic [NB*256-1:0] exp_b;
    logic [31:0]   hdr_w[HW];
    logic [31:0]   nonce_model = '0;

    initial begin
        forever begin
            if (hmac_enable === 1'b1) begin
                automatic logic [1311:0] d = hmac_data;
                automatic int lat = $urandom_range(lat_max, lat_min);
                automatic bit aborted = 1'b0;
                obs_q.push_back(d);
                enable_count++;
                if (spur_in_issue) begin
                    spur_hash = {8{32'($urandom)}};
                    spur_issue_done = 1'b1;
                end
                @(negedge clk);
                spur_issue_done = 1'b0;
                for (int c = 0; c < lat; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst) aborted = 1'b1;
                    if (!aborted && hmac_data !== d) stable_err++;
                end
                resp_hash = {8{d[31:0] ^ tag}};
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic build_expected();
        logic [639:0] h;
        for (int k = 0; k < HW; k++) h[639-32*k -: 32] = hdr_w[k];
`ifdef PBKDF2_NONCE_INSERT_EN
        h[31:0] = nonce_model;
`endif
        exp_q.delete();
        for (int i = 1; i <= NB; i++) begin
            exp_q.push_back({h, h, 32'(i)});
            exp_b[(NB-i)*256 +: 256] = {8{32'(i) ^ tag}};
        end
    endtask

    task automatic random_header();
        for (int k = 0; k < HW; k++) hdr_w[k] = $urandom;
    endtask

    task automatic send_words(input int lo, input int hi, output bit ok);
        ok = 1'b1;
        for (int k = lo; k <= hi; k++) begin
            word_in = hdr_w[k];
            word_valid = 1'b1;
            for (int c = 0; c < 200 && !word_ready; c++) begin @(posedge clk); #1; end
            if (!word_ready) begin ok = 1'b0; word_valid = 1'b0; return; end
            @(posedge clk); #1;
        end
        word_valid = 1'b0;
    endtask

    task automatic wait_b_valid(output bit ok);
        for (int c = 0; c < 3000 && !b_valid; c++) begin @(posedge clk); #1; end
        ok = b_valid;
    endtask

    task automatic release_b();
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL reset_word_ready: got %b want 0", word_ready); end
        n_checks++; if (hmac_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", hmac_enable); end
        n_checks++; if (hmac_data !== '0) begin n_fail++; $display("FAIL reset_hmac_data: got %h want 0", hmac_data); end
        n_checks++; if (b_out !== '0) begin n_fail++; $display("FAIL reset_b_out: got %h want 0", b_out); end
        n_checks++; if (b_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_valid_busy: got %b%b want 00", b_valid, busy); end
        rst = 1'b0;
        #1;
        n_checks++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL idle_word_ready: got %b want 1", word_ready); end
    endtask

    task automatic test_basic();
        bit ok;
        for (int k = 0; k < HW; k++) hdr_w[k] = 32'h0100_0000 + 32'(k);
        tag = '0; lat_min = 10; lat_max = 10;
        build_expected();
        obs_q.delete();
        send_words(0, HW-1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_send: got timeout want accepted"); end
        wait_b_valid(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_b_valid: got 0 want 1"); end
        n_checks++; if (obs_q.size() !== NB) begin n_fail++; $display("FAIL basic_enables: got %0d want %0d", obs_q.size(), NB); end
        for (int i = 0; i < NB && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_data%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (b_out !== exp_b) begin n_fail++; $display("FAIL basic_b_out: got %h want %h", b_out, exp_b); end
        n_checks++; if (word_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_out_flags: got %b%b want 01", word_ready, busy); end
        release_b();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [NB*256-1:0] snap;
        random_header(); tag = $urandom; lat_min = 1; lat_max = 6;
        build_expected();
        obs_q.delete();
        send_words(0, HW-1, ok);
        wait_b_valid(ok);
        n_checks++; if (!ok || b_out !== exp_b) begin n_fail++; $display("FAIL bp_b_out: got %h want %h", b_out, exp_b); end
        snap = exp_b;
        word_valid = 1'b1; word_in = $urandom;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            n_checks++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: cycle %0d got %b want 1", c, b_valid); end
            n_checks++; if (b_out !== snap) begin n_fail++; $display("FAIL bp_hold_b_out: cycle %0d got %h want %h", c, b_out, snap); end
            n_checks++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL bp_word_ready: cycle %0d got %b want 0", c, word_ready); end
        end
        word_valid = 1'b0;
        release_b();
        n_checks++; if (b_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: got valid %b busy %b want 0 0", b_valid, busy); end
        n_checks++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready: got %b want 1", word_ready); end
        n_checks++; if (b_out !== snap) begin n_fail++; $display("FAIL bp_b_out_kept: got %h want %h", b_out, snap); end
    endtask

    task automatic test_gap();
        bit ok;
        int base;
        for (int k = 0; k < HW; k++) hdr_w[k] = 32'h0100_0000 + 32'(k);
        tag = '0; lat_min = 3; lat_max = 10;
        build_expected();
        obs_q.delete();
        base = enable_count;
        send_words(0, 9, ok);
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            n_checks++; if (hmac_enable !== 1'b0 || word_ready !== 1'b1) begin n_fail++; $display("FAIL gap_stall: cycle %0d got en %b rdy %b want 0 1", c, hmac_enable, word_ready); end
        end
        send_words(10, HW-1, ok);
        wait_b_valid(ok);
        n_checks++; if (obs_q.size() !== NB || enable_count - base !== NB) begin n_fail++; $display("FAIL gap_enables: got %0d want %0d", obs_q.size(), NB); end
        for (int i = 0; i < NB && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL gap_data%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (b_out !== exp_b) begin n_fail++; $display("FAIL gap_b_out: got %h want %h", b_out, exp_b); end
        release_b();
    endtask

    task automatic test_spurious();
        bit ok;
        random_header(); tag = $urandom; lat_min = 2; lat_max = 8;
        build_expected();
        obs_q.delete();
        send_words(0, 4, ok);
        spur_hash = {8{32'($urandom)}};
        spur_load_done = 1'b1;
        @(posedge clk); #1;
        spur_load_done = 1'b0;
        spur_in_issue = 1'b1;
        send_words(5, HW-1, ok);
        wait_b_valid(ok);
        spur_in_issue = 1'b0;
        n_checks++; if (obs_q.size() !== NB) begin n_fail++; $display("FAIL spur_enables: got %0d want %0d", obs_q.size(), NB); end
        for (int i = 0; i < NB && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL spur_data%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (b_out !== exp_b) begin n_fail++; $display("FAIL spur_b_out: got %h want %h", b_out, exp_b); end
        release_b();
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int base;
        random_header(); tag = $urandom; lat_min = 10; lat_max = 10;
        base = enable_count;
        send_words(0, HW-1, ok);
        for (int c = 0; c < 500 && enable_count < base + 3; c++) begin @(posedge clk); #1; end
        n_checks++; if (enable_count !== base + 3) begin n_fail++; $display("FAIL rstw_reach_idx3: got %0d want %0d", enable_count - base, 3); end
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (word_ready !== 1'b0 || hmac_enable !== 1'b0 || b_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstw_flags: got %b%b%b%b want 0000", word_ready, hmac_enable, b_valid, busy); end
        n_checks++; if (hmac_data !== '0 || b_out !== '0) begin n_fail++; $display("FAIL rstw_data: got %h / %h want 0", hmac_data, b_out); end
        rst = 1'b0;
        nonce_model = '0;
        repeat (15) begin @(posedge clk); #1; end
        n_checks++; if (b_out !== '0 || busy !== 1'b0 || word_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_late_done: got b_out %h busy %b rdy %b want 0 0 1", b_out, busy, word_ready); end
        random_header(); tag = $urandom; lat_min = 1; lat_max = 5;
        build_expected();
        obs_q.delete();
        send_words(0, HW-1, ok);
        wait_b_valid(ok);
        n_checks++; if (obs_q.size() !== NB) begin n_fail++; $display("FAIL rstw_enables: got %0d want %0d", obs_q.size(), NB); end
        for (int i = 0; i < NB && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstw_data%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (b_out !== exp_b) begin n_fail++; $display("FAIL rstw_b_out: got %h want %h", b_out, exp_b); end
        release_b();
    endtask

`ifdef PBKDF2_NONCE_INSERT_EN
    task automatic test_nonce();
        bit ok;
        nonce_in = 32'hDEAD_BEEF; nonce_load = 1'b1;
        @(posedge clk); #1;
        nonce_load = 1'b0;
        nonce_model = 32'hDEAD_BEEF;
        random_header(); tag = $urandom; lat_min = 2; lat_max = 6;
        build_expected();
        obs_q.delete();
        send_words(0, 7, ok);
        nonce_in = 32'h1234_5678; nonce_load = 1'b1;
        send_words(8, HW-1, ok);
        nonce_load = 1'b0;
        wait_b_valid(ok);
        n_checks++; if (obs_q.size() !== NB) begin n_fail++; $display("FAIL nonce_enables: got %0d want %0d", obs_q.size(), NB); end
        for (int i = 0; i < NB && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL nonce_data%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0][703:672] !== 32'hDEAD_BEEF || obs_q[0][63:32] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL nonce_words: got %h %h want deadbeef", obs_q[0][703:672], obs_q[0][63:32]); end
        end
        release_b();
    endtask
`endif

    task automatic test_back_to_back();
        bit ok;
        for (int j = 0; j < 3; j++) begin
            random_header(); tag = $urandom; lat_min = 1; lat_max = 12;
            build_expected();
            obs_q.delete();
            send_words(0, HW-1, ok);
            wait_b_valid(ok);
            n_checks++; if (obs_q.size() !== NB) begin n_fail++; $display("FAIL b2b%0d_enables: got %0d want %0d", j, obs_q.size(), NB); end
            for (int i = 0; i < NB && i < obs_q.size(); i++) begin
                n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b%0d_data%0d: got %h want %h", j, i, obs_q[i], exp_q[i]); end
            end
            n_checks++; if (b_out !== exp_b) begin n_fail++; $display("FAIL b2b%0d_b_out: got %h want %h", j, b_out, exp_b); end
            repeat ($urandom_range(5, 0)) begin @(posedge clk); #1; end
            release_b();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gap();
        test_spurious();
        test_reset_in_wait();
`ifdef PBKDF2_NONCE_INSERT_EN
        test_nonce();
`endif
        test_back_to_back();
        n_checks++; if (stable_err !== 0) begin n_fail++; $display("FAIL hmac_data_stable: got %0d changes want 0", stable_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pbkdf2_block_ctrl.md
Name: pbkdf2_block_ctrl

Overview:
- Upstream/downstream controller for the 164-byte HMAC-SHA256 stage in the scrypt PBKDF2 front end.
- Accepts an 80-byte block header as a 32-bit word stream and builds the 1312-bit HMAC input {header, header, INT(i)}.
- Issues one HMAC request per block index i = 1..NUM_BLOCKS and collects the 256-bit results into the scrypt B vector.
- Presents B to the mixing stage with a valid/ready handshake.

Parameters:
- NUM_BLOCKS, 4, number of PBKDF2 output blocks produced per header; B width = NUM_BLOCKS*256.
- HDR_WORDS, 20, number of 32-bit header words per job; fixed at 20 for the 80-byte header.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- word_in  input  32  header word, first word = most significant header bytes
- word_valid  input  1  word_in valid
- word_ready  output  1  controller accepts word_in this cycle
- hmac_data  output  1312  HMAC input: [1311:672] key = header, [671:32] salt = header, [31:0] = block index
- hmac_enable  output  1  one-cycle start pulse to the HMAC stage
- hmac_hash  input  256  HMAC result
- hmac_hash_done  input  1  HMAC result valid (pulse)
- b_out  output  NUM_BLOCKS*256  collected PBKDF2 output; block 1 in the MS 256 bits
- b_valid  output  1  b_out complete and stable
- b_ready  input  1  consumer accepts b_out
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clk edge) values: state=IDLE, word_ready=0, hmac_enable=0, hmac_data=0, b_out=0, b_valid=0, busy=0, word and index counters=0. Reset overrides any in-flight job; a late hmac_hash_done after reset is ignored.
- States: IDLE, LOAD, ISSUE, WAIT, OUT.
- IDLE:
  - word_ready=1.
  - A word_valid handshake stores word 0 into header[639:608], sets the word count to 1, and moves to LOAD.
- LOAD:
  - word_ready=1.
  - Each handshake stores word k into header[639-32k -: 32].
  - After word HDR_WORDS-1 is accepted: index=1, go to ISSUE.
  - A gap in word_valid simply stalls; there is no timeout.
- ISSUE:
  - word_ready=0.
  - hmac_data = {header, header, index[31:0]}, held stable from this cycle until the matching hash_done.
  - hmac_enable=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - hmac_hash_done is sampled only in this state; a hash_done in any other state is ignored.
  - On hash_done: store hmac_hash into b_out[NUM_BLOCKS*256-1-256*(index-1) -: 256].
  - If index==NUM_BLOCKS, go to OUT; otherwise index+1 and return to ISSUE.
  - Minimum spacing between enable pulses is 2 cycles.
- OUT:
  - b_valid=1 and b_out held stable.
  - When b_valid & b_ready: b_valid=0 next cycle, go to IDLE. b_out keeps its value until overwritten by the next job.
  - word_ready=0 throughout OUT; the next header cannot preload.
- Block index is a 32-bit big-endian integer; index=1 gives hmac_data[31:0]=32'h00000001.
- Latency: 20 word cycles + NUM_BLOCKS*(1 + HMAC latency + 1) + 1 to b_valid.

Optional Feature:
- Macro: PBKDF2_NONCE_INSERT_EN.
- Defined:
  - Adds port nonce_in (input, 32) and nonce_load (input, 1).
  - A nonce_load pulse in IDLE or OUT latches nonce_in.
  - On leaving LOAD, header[31:0] (word 19) is replaced with the latched nonce, so a host can sweep nonces without resending the header.
  - nonce_load in any other state is ignored.
- Undefined: no extra ports; word 19 is used as streamed.

Test Plan:
- Stream words 32'h01000000..32'h01000013, HMAC model returns hash = {8{index}} after 10 cycles -> 4 enable pulses, hmac_data[31:0] = 1,2,3,4, header bits [639:608] = 32'h01000000, b_out = {{8{32'h1}},{8{32'h2}},{8{32'h3}},{8{32'h4}}}, b_valid=1.
- Hold b_ready=0 for 50 cycles in OUT -> b_valid stays 1, b_out stable, word_ready=0; b_ready=1 -> b_valid=0 next cycle, state IDLE, word_ready=1.
- word_valid deasserted for 7 cycles mid-header (after word 9) -> no ISSUE until all 20 words are accepted; hmac_data is identical to the gap-free run.
- Spurious hmac_hash_done during LOAD and ISSUE -> b_out unchanged, index unchanged.
- Assert rst in WAIT for index 3, then a hash_done arrives -> all outputs at reset values, hash ignored, the next job starts cleanly from index 1.
- With PBKDF2_NONCE_INSERT_EN: nonce_in=32'hDEADBEEF loaded in IDLE -> hmac_data[703:672] and [63:32] = 32'hDEADBEEF.
